fp32_divider_seq: RTL

Iterative IEEE-754 single-precision divider, the inverse companion of the combinational FP32 multiplier in the FP ALU. It computes a_operand / b_operand with one restoring-division quotient bit per clock and reports the same Exception/Overflow/Underflow flags as the multiplier, plus DivByZero. It sits beside the multiplier in the ALU datapath, behind a valid/ready handshake on both sides.

---
 rtl/fp32_pkg.sv | 20 ++
 rtl/fp_mant_div_step.sv | 19 +
 rtl/fp32_divider_seq.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/fp32_pkg.sv
// Shared FP32 definitions: field positions, exponent limits and the divider state encoding.
package fp32_pkg;

  localparam logic [7:0] EXP_MAX  = 8'hFF;
  localparam int         QBITS    = 26;

  localparam int SIGN_BIT = 31;
  localparam int EXP_MSB  = 30;
  localparam int EXP_LSB  = 23;
  localparam int MANT_MSB = 22;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    NORM,
    DONE
  } state_t;

endpackage

// File: rtl/fp_mant_div_step.sv
// One restoring-division step on 24-bit significands: emits a quotient bit and the shifted remainder.
module fp_mant_div_step (
  input  logic [24:0] rem_in,
  input  logic [23:0] div_in,
  output logic        q_bit,
  output logic [24:0] rem_out
);

  logic [24:0] diff;
  logic [24:0] kept;

  always_comb begin
    diff    = rem_in - {1'b0, div_in};
    q_bit   = (rem_in >= {1'b0, div_in});
    kept    = q_bit ? diff : rem_in;
    rem_out = kept << 1;
  end

endmodule

// File: rtl/fp32_divider_seq.sv
// Iterative FP32 divider, one quotient bit per clock, valid/ready on both sides.
// Define FP_DIV_ROUND_EN for round-to-nearest-even; otherwise the mantissa is truncated.
module fp32_divider_seq
  import fp32_pkg::*;
#(
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        ready,
  input  logic [31:0] a_operand,
  input  logic [31:0] b_operand,
  output logic        valid_out,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        Exception,
  output logic        Overflow,
  output logic        Underflow,
  output logic        DivByZero
);

  localparam logic [4:0] LAST_COUNT = 5'(QBITS - 1);

  state_t             state, state_next;
  logic [31:0]        a_reg, b_reg;
  logic               sign_reg;
  logic signed [9:0]  exp_reg;
  logic [24:0]        rem_reg;
  logic [23:0]        div_reg;
  logic [QBITS-1:0]   q_reg;
  logic [4:0]         count_reg;

  logic               step_bit;
  logic [24:0]        step_rem;

  logic               sign_prep, is_exc, a_zero, b_zero, special;
  logic signed [9:0]  exp_prep;

  logic signed [9:0]  exp_norm;
  logic [22:0]        mant_norm;
  logic               norm_ovf, norm_unf;
  logic [31:0]        norm_result;
`ifdef FP_DIV_ROUND_EN
  logic               guard, sticky;
  logic [23:0]        mant_inc;
`endif

  fp_mant_div_step u_step (
    .rem_in  (rem_reg),
    .div_in  (div_reg),
    .q_bit   (step_bit),
    .rem_out (step_rem)
  );

  assign ready     = (state == IDLE);
  assign valid_out = (state == DONE);

  // Operand classification; denormals count as zero since only the exponent field is tested.
  always_comb begin
    sign_prep = a_reg[SIGN_BIT] ^ b_reg[SIGN_BIT];
    is_exc    = (a_reg[EXP_MSB:EXP_LSB] == EXP_MAX) || (b_reg[EXP_MSB:EXP_LSB] == EXP_MAX);
    a_zero    = (a_reg[EXP_MSB:EXP_LSB] == 8'd0);
    b_zero    = (b_reg[EXP_MSB:EXP_LSB] == 8'd0);
    special   = is_exc || a_zero || b_zero;
    exp_prep  = {2'b00, a_reg[EXP_MSB:EXP_LSB]} - {2'b00, b_reg[EXP_MSB:EXP_LSB]} + 10'(EXP_BIAS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = PREP;
      PREP:    state_next = special ? DONE : ITER;
      ITER:    if (count_reg == LAST_COUNT) state_next = NORM;
      NORM:    state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // q[25] clear means the quotient is below 1.0, so shift one more bit in and drop the exponent.
  always_comb begin
    exp_norm  = q_reg[QBITS-1] ? exp_reg : exp_reg - 10'sd1;
    mant_norm = q_reg[QBITS-1] ? q_reg[24:2] : q_reg[23:1];
`ifdef FP_DIV_ROUND_EN
    guard    = q_reg[QBITS-1] ? q_reg[1] : q_reg[0];
    sticky   = (q_reg[QBITS-1] & q_reg[0]) | (rem_reg != 25'd0);
    mant_inc = {1'b0, mant_norm} + 24'd1;
    if (guard & (sticky | mant_norm[0])) begin
      mant_norm = mant_inc[22:0];
      if (mant_inc[23]) exp_norm = exp_norm + 10'sd1;
    end
`endif
    norm_ovf = (exp_norm >= 10'sd255);
    norm_unf = (exp_norm <= 10'sd0);
    if (norm_ovf)      norm_result = {sign_reg, EXP_MAX, 23'd0};
    else if (norm_unf) norm_result = {sign_reg, 31'd0};
    else               norm_result = {sign_reg, exp_norm[7:0], mant_norm};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_reg      <= '0;
      b_reg      <= '0;
      sign_reg   <= 1'b0;
      exp_reg    <= '0;
      rem_reg    <= '0;
      div_reg    <= '0;
      q_reg      <= '0;
      count_reg  <= '0;
      result     <= '0;
      Exception  <= 1'b0;
      Overflow   <= 1'b0;
      Underflow  <= 1'b0;
      DivByZero  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a_operand;
            b_reg <= b_operand;
          end
        end
        PREP: begin
          sign_reg  <= sign_prep;
          exp_reg   <= exp_prep;
          rem_reg   <= {2'b01, a_reg[MANT_MSB:0]};
          div_reg   <= {1'b1, b_reg[MANT_MSB:0]};
          q_reg     <= '0;
          count_reg <= '0;
          Exception <= is_exc;
          DivByZero <= !is_exc && b_zero;
          Overflow  <= 1'b0;
          Underflow <= 1'b0;
          if (is_exc)      result <= 32'd0;
          else if (b_zero) result <= {sign_prep, EXP_MAX, 23'd0};
          else if (a_zero) result <= {sign_prep, 31'd0};
        end
        ITER: begin
          rem_reg   <= step_rem;
          q_reg     <= {q_reg[QBITS-2:0], step_bit};
          count_reg <= count_reg + 5'd1;
        end
        NORM: begin
          result    <= norm_result;
          Overflow  <= norm_ovf;
          Underflow <= !norm_ovf && norm_unf;
          Exception <= 1'b0;
          DivByZero <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
